// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execute check: ARM condition codes
// and the bit positions of N, Z, C, V inside the 4-bit flag vectors.
package cond_pkg;

    typedef enum logic [3:0] {
        CondEq = 4'h0,
        CondNe = 4'h1,
        CondCs = 4'h2,
        CondCc = 4'h3,
        CondMi = 4'h4,
        CondPl = 4'h5,
        CondVs = 4'h6,
        CondVc = 4'h7,
        CondHi = 4'h8,
        CondLs = 4'h9,
        CondGe = 4'hA,
        CondLt = 4'hB,
        CondGt = 4'hC,
        CondLe = 4'hD,
        CondAl = 4'hE,
        CondNv = 4'hF
    } cond_code_t;

    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

endpackage

// File: rtl/cond_check_if.sv
// Execute-stage bundle into the condition checker and the memory-stage
// controls, flags and event counters coming back out of it.
interface cond_check_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             valid_e;
    logic [3:0]       cond_e;
    logic [1:0]       flag_write_e;
    logic [3:0]       alu_flags;
    logic             pcs_e;
    logic             reg_write_e;
    logic             mem_write_e;

    logic [3:0]       flags;
    logic             cond_ex;
    logic             valid_m;
    logic             pcs_m;
    logic             reg_write_m;
    logic             mem_write_m;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] squash_cnt;

    // Pipeline side: drives the execute stage, observes the results
    modport master (
        output stall, flush, valid_e, cond_e, flag_write_e, alu_flags,
        output pcs_e, reg_write_e, mem_write_e,
        input  flags, cond_ex, valid_m, pcs_m, reg_write_m, mem_write_m,
        input  exec_cnt, squash_cnt
    );

    // Checker side
    modport slave (
        input  stall, flush, valid_e, cond_e, flag_write_e, alu_flags,
        input  pcs_e, reg_write_e, mem_write_e,
        output flags, cond_ex, valid_m, pcs_m, reg_write_m, mem_write_m,
        output exec_cnt, squash_cnt
    );
endinterface

// File: rtl/cond_eval.sv
// Pure combinational ARM condition-field decode against an NZCV vector.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       ex
);

    logic n, z, c, v;

    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];

    // Decode the condition field; every encoding is listed so no default is needed
    always_comb begin
        ex = 1'b0;
        unique case (cond_code_t'(cond))
            CondEq: ex = z;
            CondNe: ex = ~z;
            CondCs: ex = c;
            CondCc: ex = ~c;
            CondMi: ex = n;
            CondPl: ex = ~n;
            CondVs: ex = v;
            CondVc: ex = ~v;
            CondHi: ex = c & ~z;
            CondLs: ex = ~c | z;
            CondGe: ex = (n == v);
            CondLt: ex = (n != v);
            CondGt: ex = ~z & (n == v);
            CondLe: ex = z | (n != v);
            CondAl: ex = 1'b1;
            CondNv: ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_check.sv
// Execute-stage condition check: holds the architectural NZCV flags, gates the
// execute controls into the execute-to-memory register and counts executed and
// squashed instructions with saturating counters.
module cond_check
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic         clk,
    input logic         reset_n,
    cond_check_if.slave bus
);

    logic [3:0]       flags_q, flags_d;
    logic             valid_m_q, valid_m_d;
    logic             pcs_m_q, pcs_m_d;
    logic             reg_write_m_q, reg_write_m_d;
    logic             mem_write_m_q, mem_write_m_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    logic cond_ex;
    logic live;
    logic commit;
    logic squash;

    // Condition is tested against the registered flags, never the ALU bypass
    cond_eval u_cond_eval (
        .cond  (bus.cond_e),
        .flags (flags_q),
        .ex    (cond_ex)
    );

    // A live instruction is one that leaves execute this cycle and is not flushed
    assign live   = bus.valid_e & ~bus.flush & ~bus.stall;
    assign commit = live & cond_ex;
    assign squash = live & ~cond_ex;

    // Next-state: flag fields, gated memory-stage controls, saturating counters
    always_comb begin
        flags_d       = flags_q;
        valid_m_d     = valid_m_q;
        pcs_m_d       = pcs_m_q;
        reg_write_m_d = reg_write_m_q;
        mem_write_m_d = mem_write_m_q;
        exec_cnt_d    = exec_cnt_q;
        squash_cnt_d  = squash_cnt_q;

        if (commit && bus.flag_write_e[1]) begin
            flags_d[N_BIT] = bus.alu_flags[N_BIT];
            flags_d[Z_BIT] = bus.alu_flags[Z_BIT];
        end
        if (commit && bus.flag_write_e[0]) begin
            flags_d[C_BIT] = bus.alu_flags[C_BIT];
            flags_d[V_BIT] = bus.alu_flags[V_BIT];
        end

        if (!bus.stall) begin
            valid_m_d     = bus.valid_e & ~bus.flush;
            pcs_m_d       = bus.pcs_e & commit;
            reg_write_m_d = bus.reg_write_e & commit;
            mem_write_m_d = bus.mem_write_e & commit;
        end

        if (commit && (exec_cnt_q != '1)) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if (squash && (squash_cnt_q != '1)) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    // State register; reset clears everything and drops any in-flight instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q       <= 4'b0000;
            valid_m_q     <= 1'b0;
            pcs_m_q       <= 1'b0;
            reg_write_m_q <= 1'b0;
            mem_write_m_q <= 1'b0;
            exec_cnt_q    <= '0;
            squash_cnt_q  <= '0;
        end else begin
            flags_q       <= flags_d;
            valid_m_q     <= valid_m_d;
            pcs_m_q       <= pcs_m_d;
            reg_write_m_q <= reg_write_m_d;
            mem_write_m_q <= mem_write_m_d;
            exec_cnt_q    <= exec_cnt_d;
            squash_cnt_q  <= squash_cnt_d;
        end
    end

    assign bus.flags       = flags_q;
    assign bus.cond_ex     = cond_ex;
    assign bus.valid_m     = valid_m_q;
    assign bus.pcs_m       = pcs_m_q;
    assign bus.reg_write_m = reg_write_m_q;
    assign bus.mem_write_m = mem_write_m_q;
    assign bus.exec_cnt    = exec_cnt_q;
    assign bus.squash_cnt  = squash_cnt_q;

endmodule

// File: doc/cond_check.md
COND_CHECK -- requirements
Module: cond_check

Interface
REQ-001 Parameter CNT_W, default 16, width of the executed and squashed event counters.
REQ-002 clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 stall  input  1  hold the execute-to-memory register and the flags; no state change except reset.
REQ-005 flush  input  1  squash the instruction currently in execute.
REQ-006 valid_e  input  1  an instruction is present in execute.
REQ-007 cond_e  input  4  ARM condition field of the execute instruction.
REQ-008 flag_write_e  input  2  bit1 writes N and Z, bit0 writes C and V.
REQ-009 alu_flags  input  4  ALU result flags: [3]=N, [2]=Z, [1]=C, [0]=V.
REQ-010 pcs_e, reg_write_e, mem_write_e  input  1 each  ungated control bits from decode.
REQ-011 flags  output  4  architectural NZCV register, in the same bit order.
REQ-012 cond_ex  output  1  combinational result of the condition test for the execute instruction.
REQ-013 valid_m, pcs_m, reg_write_m, mem_write_m  output  1 each  registered, gated controls for the memory stage.
REQ-014 exec_cnt, squash_cnt  output  CNT_W each  saturating event counters.

Function
REQ-015 cond_ex is evaluated from the registered flags only; alu_flags in the same cycle have no effect on it.
REQ-016 Condition decode:
- EQ 0000: Z. NE 0001: !Z.
- CS 0010: C. CC 0011: !C.
- MI 0100: N. PL 0101: !N.
- VS 0110: V. VC 0111: !V.
- HI 1000: C&!Z. LS 1001: !C|Z.
- GE 1010: N==V. LT 1011: N!=V.
- GT 1100: !Z&(N==V). LE 1101: Z|(N!=V).
- AL 1110: 1. NV 1111: 0.
REQ-017 commit = valid_e & cond_ex & !flush & !stall.
REQ-018 When commit is high and flag_write_e[1] is set, flags[3:2] load alu_flags[3:2] at the clock edge.
REQ-019 When commit is high and flag_write_e[0] is set, flags[1:0] load alu_flags[1:0] at the clock edge.
REQ-020 The two flag write fields are independent; both may update in the same cycle.
REQ-021 When stall is low, valid_m takes valid_e & !flush at the clock edge.
REQ-022 When stall is low, pcs_m, reg_write_m and mem_write_m take their _e input ANDed with commit at the clock edge.
REQ-023 A squashed instruction (valid, cond_ex=0, not flushed) still advances with valid_m=1 and all gated controls at 0.
REQ-024 Latency: one cycle from execute to the _m outputs; flags are visible to the next instruction's test one cycle after commit.
REQ-025 When stall is high, every register holds its value, including flags, the _m outputs and both counters.
REQ-026 flush has priority over the condition result.
REQ-027 A flushed instruction writes no flags, increments neither counter and produces valid_m=0.
REQ-028 exec_cnt increments on commit.
REQ-029 squash_cnt increments when valid_e & !cond_ex & !flush & !stall.
REQ-030 Both counters saturate at all-ones and do not wrap.

Reset
REQ-031 While reset_n is low, flags=0000, all _m outputs=0 and both counters=0, independent of clk.
REQ-032 Reset asserted mid-operation discards the in-flight instruction.
REQ-033 The first edge after reset release behaves as a normal cycle.

Structure
REQ-034 A shared package cond_pkg holds the condition-code enum (EQ..NV) and the flag bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
REQ-035 The combinational decode is one sub-module, cond_eval, with inputs cond[3:0] and flags[3:0] and output ex.
REQ-036 All state lives in cond_check.

Verification
REQ-037 Reset, then valid_e=1, cond_e=1110, flag_write_e=11, alu_flags=0100 -> next cycle flags=0100, exec_cnt=1.
REQ-038 With flags=0100, cond_e=0001 (NE), reg_write_e=1, flag_write_e=11, alu_flags=1000 -> cond_ex=0, reg_write_m=0, valid_m=1, flags stay 0100, squash_cnt increments.
REQ-039 Back-to-back: an AL instruction sets flags=0000, then an EQ instruction the next cycle -> cond_ex=0 for the EQ (the earlier Z=1 is already overwritten).
REQ-040 stall=1 for 3 cycles with a committing instruction -> flags, _m outputs and counters unchanged; update occurs on the edge after stall falls.
REQ-041 flush=1 with cond_e=1110, mem_write_e=1 -> valid_m=0, mem_write_m=0, flags and counters unchanged.
REQ-042 With CNT_W=4, 17 commits -> exec_cnt=1111.
REQ-043 Assert reset_n low between edges -> all outputs 0 immediately.
